spdif_encoder: RTL and testbench

Transmit-side counterpart of the S/PDIF receiver. It captures stereo PCM from a Philips I2S stream (bck/ws/d0) and holds the latest left/right words. It emits a free-running IEC 60958 biphase-mark (BMC) S/PDIF line with B/M/W preambles, a 192-frame channel-status block, and even parity. It sits between the audio source and the optical/coax output pad, and loops back cleanly into the receiver for self-test.

---
 rtl/spdif_encoder.sv | 137 +++++++++++++
 tb/tb_spdif_encoder.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spdif_encoder.sv
// I2S-to-S/PDIF transmitter: captures stereo PCM from a Philips I2S stream and
// emits a free-running IEC 60958 biphase-mark line with B/M/W preambles.
module spdif_encoder #(
  parameter int unsigned HALF_CLKS = 8,
  parameter logic [31:0] CS_WORD   = 32'h0000_0004
) (
  input  logic clk_in,
  input  logic reset,
  input  logic i2s_bck,
  input  logic i2s_ws,
  input  logic i2s_d0,
  output logic spdif_out,
  output logic frame_start,
  output logic block_start
);

  typedef enum logic {SUB_L = 1'b0, SUB_R = 1'b1} sub_t;

  localparam logic [7:0] PRE_B     = 8'b1110_1000;
  localparam logic [7:0] PRE_M     = 8'b1110_0010;
  localparam logic [7:0] PRE_W     = 8'b1110_0100;
  localparam logic [7:0] HALF_LAST = 8'(HALF_CLKS - 1);

  // I2S capture
  logic [1:0]  bck_s, ws_s, d0_s;
  logic        bck_d, ws_prev, bck_rise;
  logic [4:0]  cnt;
  logic [23:0] cap, cap_ins, hold_l, hold_r;

  always_comb begin
    bck_rise = bck_s[1] & ~bck_d;
    cap_ins  = cap;
    if (cnt < 5'd24) cap_ins[5'd23 - cnt] = d0_s[1];
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      bck_s   <= '0;
      ws_s    <= '0;
      d0_s    <= '0;
      bck_d   <= 1'b0;
      ws_prev <= 1'b0;
      cnt     <= '0;
      cap     <= '0;
      hold_l  <= '0;
      hold_r  <= '0;
    end else begin
      bck_s <= {bck_s[0], i2s_bck};
      ws_s  <= {ws_s[0], i2s_ws};
      d0_s  <= {d0_s[0], i2s_d0};
      bck_d <= bck_s[1];
      if (bck_rise) begin
        // A ws change marks this bit as the old word's LSB: absorb it, then commit.
        if (ws_s[1] != ws_prev) begin
          if (!ws_prev) hold_l <= cap_ins;
          else          hold_r <= cap_ins;
          cap     <= '0;
          cnt     <= '0;
          ws_prev <= ws_s[1];
        end else begin
          cap <= cap_ins;
          if (cnt != 5'd31) cnt <= cnt + 5'd1;
        end
      end
    end
  end

  // Frame sequencer and line coder
  logic [7:0]  hcnt;
  logic [5:0]  hidx;
  sub_t        sub;
  logic [7:0]  frame;
  logic [23:0] tx_l, tx_r, word;
  logic [4:0]  slot;
  logic [8:0]  pat9;
  logic [3:0]  pk;
  logic        load, c_bit, parity, data_bit, toggle;

  always_comb begin
    load   = (hcnt == 8'd0) && (hidx == 6'd0) && (sub == SUB_L);
    word   = (sub == SUB_R) ? tx_r : tx_l;
    c_bit  = (frame < 8'd32) ? CS_WORD[frame[4:0]] : 1'b0;
    parity = ^{word, c_bit};
    slot   = hidx[5:1];
    case (slot)
      5'd28, 5'd29: data_bit = 1'b0;
      5'd30:        data_bit = c_bit;
      5'd31:        data_bit = parity;
      default:      data_bit = word[slot - 5'd4];
    endcase
    if (sub == SUB_R)       pat9 = {1'b0, PRE_W};
    else if (frame == 8'd0) pat9 = {1'b0, PRE_B};
    else                    pat9 = {1'b0, PRE_M};
    pk = {1'b0, hidx[2:0]};
    // Preambles are coded as level changes so the pattern follows the prior line level.
    if (hidx < 6'd8)   toggle = pat9[4'd7 - pk] ^ pat9[4'd8 - pk];
    else if (!hidx[0]) toggle = 1'b1;
    else               toggle = data_bit;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      hcnt        <= '0;
      hidx        <= '0;
      sub         <= SUB_L;
      frame       <= '0;
      tx_l        <= '0;
      tx_r        <= '0;
      spdif_out   <= 1'b0;
      frame_start <= 1'b0;
      block_start <= 1'b0;
    end else begin
      frame_start <= load;
      block_start <= load && (frame == 8'd0);
      if (hcnt == 8'd0) spdif_out <= spdif_out ^ toggle;
      if (load) begin
        tx_l <= hold_l;
        tx_r <= hold_r;
      end
      if (hcnt == HALF_LAST) begin
        hcnt <= '0;
        hidx <= hidx + 6'd1;
        if (hidx == 6'd63) begin
          if (sub == SUB_R) begin
            sub   <= SUB_L;
            frame <= (frame == 8'd191) ? 8'd0 : frame + 8'd1;
          end else begin
            sub <= SUB_R;
          end
        end
      end else begin
        hcnt <= hcnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_spdif_encoder.sv
// Scoreboard bench for spdif_encoder: an I2S driver updates a hold model, frame
// expectations are queued at each frame start, a BMC decoder pops and compares.
module tb_spdif_encoder;

  localparam int H   = 2;
  localparam int F   = 128 * H;
  localparam int BLK = 192 * F;
  localparam logic [31:0] CS = 32'h0000_0004;
  localparam logic [7:0] PB = 8'b1110_1000;
  localparam logic [7:0] PM = 8'b1110_0010;
  localparam logic [7:0] PW = 8'b1110_0100;

  logic clk_in = 1'b0;
  logic reset = 1'b1;
  logic i2s_bck = 1'b0, i2s_ws = 1'b0, i2s_d0 = 1'b0;
  logic spdif_out, frame_start, block_start;

  spdif_encoder #(.HALF_CLKS(H), .CS_WORD(CS)) dut (
    .clk_in(clk_in), .reset(reset), .i2s_bck(i2s_bck), .i2s_ws(i2s_ws),
    .i2s_d0(i2s_d0), .spdif_out(spdif_out), .frame_start(frame_start),
    .block_start(block_start)
  );

  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;
  int k = -1;
  logic [23:0] model_l = '0, model_r = '0;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    int          frm;
  } exp_t;
  exp_t exp_q[$];
  exp_t push_e;

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, k);
    end
  endtask

  // Expected frame content is captured at each frame start (every F cycles from reset release).
  always @(posedge clk_in) begin
    if (reset) begin
      k <= -1;
      exp_q.delete();
    end else begin
      if ((k + 1) % F == 0) begin
        push_e.l   = model_l;
        push_e.r   = model_r;
        push_e.frm = ((k + 1) / F) % 192;
        exp_q.push_back(push_e);
      end
      k <= k + 1;
    end
  end

  logic lv [0:127];
  logic prev_lvl = 1'b0;

  task automatic decode_frame();
    exp_t e;
    logic prior, bmc_ok, cb;
    logic [7:0] got_pre, want_pre;
    logic [27:0] got_d, want_d;
    logic [23:0] w;
    int base;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_queue: got empty expected an entry (cycle %0d)", k);
      return;
    end
    e = exp_q.pop_front();
    cb = (e.frm < 32) ? CS[e.frm] : 1'b0;
    for (int s = 0; s < 2; s++) begin
      base  = 64 * s;
      prior = (s == 0) ? prev_lvl : lv[63];
      for (int i = 0; i < 8; i++) got_pre[7 - i] = lv[base + i] ^ prior;
      want_pre = (s == 1) ? PW : ((e.frm == 0) ? PB : PM);
      check1(s == 0 ? "preamble_left" : "preamble_right", 32'(got_pre), 32'(want_pre));
      bmc_ok = 1'b1;
      for (int t = 4; t < 32; t++) begin
        if (lv[base + 2 * t] == lv[base + 2 * t - 1]) bmc_ok = 1'b0;
        got_d[t - 4] = lv[base + 2 * t] ^ lv[base + 2 * t + 1];
      end
      w = (s == 0) ? e.l : e.r;
      want_d = {^w ^ cb, cb, 2'b00, w};
      check1("bmc_bit_edges", 32'(bmc_ok), 32'd1);
      check1(s == 0 ? "left_slots" : "right_slots", 32'(got_d), 32'(want_d));
    end
    prev_lvl = lv[127];
  endtask

  always @(negedge clk_in) begin
    if (k < 0) begin
      prev_lvl = 1'b0;
      check1("reset_line", 32'(spdif_out), 32'd0);
      check1("reset_frame_start", 32'(frame_start), 32'd0);
      check1("reset_block_start", 32'(block_start), 32'd0);
    end else begin
      check1("frame_start", 32'(frame_start), 32'(k % F == 0));
      check1("block_start", 32'(block_start), 32'(k % BLK == 0));
      if (k % H == 0) begin
        lv[(k % F) / H] = spdif_out;
        if ((k % F) / H == 127) decode_frame();
      end
    end
  end

  task automatic bck_edge(input logic ws_v, input logic d_v, input bit commit,
                          input logic ch, input logic [23:0] word);
    int guard;
    i2s_ws = ws_v;
    i2s_d0 = d_v;
    repeat (3) @(negedge clk_in);
    // Keep the commit clear of a tx load so the expected frame content is unambiguous.
    guard = 0;
    while (commit && ((k + 6) % F) < 6 && guard < 20) begin
      @(negedge clk_in);
      guard++;
    end
    i2s_bck = 1'b1;
    if (commit) begin
      if (ch == 1'b0) model_l = word;
      else            model_r = word;
    end
    repeat (3) @(negedge clk_in);
    i2s_bck = 1'b0;
  endtask

  task automatic send_word(input logic ch, input logic [63:0] v, input int n);
    logic [63:0] m, t;
    m = v & ((64'd1 << n) - 64'd1);
    t = (n >= 24) ? (m >> (n - 24)) : (m << (24 - n));
    for (int i = n - 1; i >= 1; i--) bck_edge(ch, m[i], 1'b0, ch, 24'd0);
    bck_edge(~ch, m[0], 1'b1, ch, t[23:0]);
  endtask

  task automatic send_pair(input logic [63:0] l, input int nl, input logic [63:0] r, input int nr);
    send_word(1'b0, l, nl);
    send_word(1'b1, r, nr);
  endtask

  initial begin
    repeat (4) @(negedge clk_in);
    reset = 1'b0;
    repeat (3 * F) @(negedge clk_in);

    send_pair(64'h80_0001, 24, 64'h0, 24);
    repeat (2 * F) @(negedge clk_in);
    send_pair(64'hA5A5, 16, 64'h5A5A, 16);
    repeat (2 * F) @(negedge clk_in);
    send_pair(64'hDEAD_BEEF, 32, 64'h1234_5678, 32);
    repeat (2 * F) @(negedge clk_in);

    for (int p = 0; p < 20; p++) begin
      send_pair({$urandom, $urandom}, int'($urandom_range(1, 32)),
                {$urandom, $urandom}, int'($urandom_range(1, 32)));
      repeat ($urandom_range(0, 300)) @(negedge clk_in);
    end

    // bck idle from here: the last words repeat through the block wrap
    while (k < 194 * F) @(negedge clk_in);

    while (k % F != 40) @(negedge clk_in);
    reset   = 1'b1;
    model_l = '0;
    model_r = '0;
    @(negedge clk_in);
    reset = 1'b0;
    repeat (3 * F + 4) @(negedge clk_in);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
